// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, framed byte and status pulses out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (input rx, output data, output valid, output frame_err, output busy);
  modport slave  (output rx, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver for an idle-low line: high start bit, LSB-first data, low stop bit.
// Mid-bit sampling from a per-bit down-counter; stuck-high lines are parked in RECOVER.
//
// state   | meaning
// IDLE    | waiting for rx_s high (start-bit detection)
// START   | counting to the start-bit mid-point
// DATA    | sampling DATA_BITS data bits
// STOP    | counting to and sampling the stop bit
// RECOVER | after a framing error, waiting for the line to return low
module uart_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_e;

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int IW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [IW-1:0] LAST_IDX    = IW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_s) begin
          idx_d = '0;
          // With HALF==0 the detection cycle is already the start-bit sample.
          if (HALF == 0) begin
            state_d = DATA;
            cnt_d   = BIT_RELOAD;
          end else begin
            state_d = START;
            cnt_d   = HALF_RELOAD;
          end
        end
      end

      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          state_d = DATA;
          cnt_d   = BIT_RELOAD;
        end else begin
          state_d = IDLE;
        end
      end

      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = BIT_RELOAD;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IW'(i)) shift_d[i] = rx_s;
          end
          if (idx_q == LAST_IDX) state_d = STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = RECOVER;
        end
      end

      RECOVER: begin
        if (!rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench: dut0 at 1 clock/bit, dut1 at 4 clocks/bit, sharing clock and reset.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   both_cnt = 0;

  int          v0_c[$], v1_c[$], f0_c[$], f1_c[$];
  logic [7:0]  v0_d[$], v1_d[$];

  uart_rx_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_if #(.DATA_BITS(8)) bus1 ();

  uart_rx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus0.valid) begin v0_c.push_back(cyc); v0_d.push_back(bus0.data); end
    if (bus1.valid) begin v1_c.push_back(cyc); v1_d.push_back(bus1.data); end
    if (bus0.frame_err) f0_c.push_back(cyc);
    if (bus1.frame_err) f1_c.push_back(cyc);
    if ((bus0.valid && bus0.frame_err) || (bus1.valid && bus1.frame_err)) both_cnt++;
  end

  task automatic clr_logs();
    v0_c.delete(); v1_c.delete(); f0_c.delete(); f1_c.delete();
    v0_d.delete(); v1_d.delete();
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d == 0) bus0.rx = v;
    else        bus1.rx = v;
  endtask

  task automatic drive_cycles(input int d, input logic v, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      set_rx(d, v);
    end
  endtask

  task automatic send_frame(input int d, input logic [7:0] b, input logic stop,
                            input int cpb, output int n0);
    @(posedge clk); #1;
    n0 = cyc;
    set_rx(d, 1'b1);
    drive_cycles(d, 1'b1, cpb - 1);
    for (int i = 0; i < 8; i++) drive_cycles(d, b[i], cpb);
    drive_cycles(d, stop, cpb);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus0.data !== 8'h00) begin n_err++; $display("FAIL rst_data0 got %h want 00", bus0.data); end
    n_cmp++; if (bus0.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid0 got %b want 0", bus0.valid); end
    n_cmp++; if (bus0.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr0 got %b want 0", bus0.frame_err); end
    n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy0 got %b want 0", bus0.busy); end
    n_cmp++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy1 got %b want 0", bus1.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_cycles(0, 1'b0, 3);
    @(negedge clk);
    n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy0 got %b want 0", bus0.busy); end
  endtask

  task automatic test_basic();
    int n0;
    clr_logs();
    send_frame(0, 8'hA5, 1'b0, 1, n0);
    drive_cycles(0, 1'b0, 6);
    n_cmp++;
    if (v0_c.size() !== 1) begin n_err++; $display("FAIL basic_vcount got %0d want 1", v0_c.size()); end
    else begin
      n_cmp++; if (v0_c[0] !== n0 + 12) begin n_err++; $display("FAIL basic_latency got %0d want %0d", v0_c[0], n0 + 12); end
      n_cmp++; if (v0_d[0] !== 8'hA5) begin n_err++; $display("FAIL basic_data got %h want a5", v0_d[0]); end
    end
    n_cmp++; if (f0_c.size() !== 0) begin n_err++; $display("FAIL basic_ferr got %0d want 0", f0_c.size()); end
  endtask

  task automatic test_frame_err();
    int n0;
    clr_logs();
    send_frame(0, 8'h3C, 1'b1, 1, n0);
    drive_cycles(0, 1'b1, 5);
    @(negedge clk);
    n_cmp++; if (bus0.busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_recover got %b want 1", bus0.busy); end
    drive_cycles(0, 1'b0, 5);
    @(negedge clk);
    n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_idle got %b want 0", bus0.busy); end
    drive_cycles(0, 1'b0, 10);
    n_cmp++;
    if (f0_c.size() !== 1) begin n_err++; $display("FAIL ferr_count got %0d want 1", f0_c.size()); end
    else begin
      n_cmp++; if (f0_c[0] !== n0 + 12) begin n_err++; $display("FAIL ferr_latency got %0d want %0d", f0_c[0], n0 + 12); end
    end
    n_cmp++; if (v0_c.size() !== 0) begin n_err++; $display("FAIL ferr_valid got %0d want 0", v0_c.size()); end
    n_cmp++; if (bus0.data !== 8'hA5) begin n_err++; $display("FAIL ferr_data_kept got %h want a5", bus0.data); end
  endtask

  task automatic test_false_start();
    int n0;
    clr_logs();
    @(posedge clk); #1;
    n0 = cyc;
    set_rx(1, 1'b1);
    @(posedge clk); #1;
    set_rx(1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus1.busy !== 1'b1) begin n_err++; $display("FAIL fs_busy_start got %b want 1 (cyc %0d)", bus1.busy, cyc - n0); end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL fs_busy_back got %b want 0", bus1.busy); end
    drive_cycles(1, 1'b0, 50);
    n_cmp++; if (v1_c.size() + f1_c.size() !== 0) begin n_err++; $display("FAIL fs_pulses got %0d want 0", v1_c.size() + f1_c.size()); end
    n_cmp++; if (bus1.data !== 8'h00) begin n_err++; $display("FAIL fs_data got %h want 00", bus1.data); end
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    clr_logs();
    send_frame(0, 8'h00, 1'b0, 1, n0);
    send_frame(0, 8'hFF, 1'b0, 1, n1);
    drive_cycles(0, 1'b0, 6);
    n_cmp++;
    if (v0_c.size() !== 2) begin n_err++; $display("FAIL b2b_count got %0d want 2", v0_c.size()); end
    else begin
      n_cmp++; if (v0_c[0] !== n0 + 12) begin n_err++; $display("FAIL b2b_first_cyc got %0d want %0d", v0_c[0], n0 + 12); end
      n_cmp++; if (v0_c[1] - v0_c[0] !== 10) begin n_err++; $display("FAIL b2b_spacing got %0d want 10", v0_c[1] - v0_c[0]); end
      n_cmp++; if (v0_d[0] !== 8'h00) begin n_err++; $display("FAIL b2b_data0 got %h want 00", v0_d[0]); end
      n_cmp++; if (v0_d[1] !== 8'hFF) begin n_err++; $display("FAIL b2b_data1 got %h want ff", v0_d[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    logic [7:0] b;
    b = 8'h5A;
    clr_logs();
    drive_cycles(0, 1'b1, 1);
    for (int i = 0; i < 4; i++) drive_cycles(0, b[i], 1);
    @(posedge clk); #1;
    set_rx(0, b[4]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_rx(0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus0.data !== 8'h00) begin n_err++; $display("FAIL rmid_data got %h want 00", bus0.data); end
    n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", bus0.busy); end
    drive_cycles(0, 1'b0, 15);
    n_cmp++; if (v0_c.size() + f0_c.size() !== 0) begin n_err++; $display("FAIL rmid_pulses got %0d want 0", v0_c.size() + f0_c.size()); end
    send_frame(0, 8'h81, 1'b0, 1, n0);
    drive_cycles(0, 1'b0, 6);
    n_cmp++;
    if (v0_c.size() !== 1) begin n_err++; $display("FAIL rmid_vcount got %0d want 1", v0_c.size()); end
    else begin
      n_cmp++; if (v0_d[0] !== 8'h81) begin n_err++; $display("FAIL rmid_data2 got %h want 81", v0_d[0]); end
      n_cmp++; if (v0_c[0] !== n0 + 12) begin n_err++; $display("FAIL rmid_latency got %0d want %0d", v0_c[0], n0 + 12); end
    end
  endtask

  task automatic test_cpb4();
    int n0;
    clr_logs();
    send_frame(1, 8'h81, 1'b0, 4, n0);
    drive_cycles(1, 1'b0, 10);
    n_cmp++;
    if (v1_c.size() !== 1) begin n_err++; $display("FAIL cpb4_vcount got %0d want 1", v1_c.size()); end
    else begin
      n_cmp++; if (v1_c[0] !== n0 + 40) begin n_err++; $display("FAIL cpb4_latency got %0d want %0d", v1_c[0], n0 + 40); end
      n_cmp++; if (v1_d[0] !== 8'h81) begin n_err++; $display("FAIL cpb4_data got %h want 81", v1_d[0]); end
    end
    n_cmp++; if (f1_c.size() !== 0) begin n_err++; $display("FAIL cpb4_ferr got %0d want 0", f1_c.size()); end
    n_cmp++; if (both_cnt !== 0) begin n_err++; $display("FAIL overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    bus0.rx = 1'b0;
    bus1.rx = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_frame_err();
    test_false_start();
    test_back_to_back();
    test_reset_mid();
    test_cpb4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, clock cycles per serial bit; legal range 1..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame, LSB first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  serial line; idle low, start bit high, stop bit low.
REQ-006 data  output  DATA_BITS  last correctly framed byte.
REQ-007 valid  output  1  one-cycle pulse; data updated this cycle.
REQ-008 frame_err  output  1  one-cycle pulse; stop bit sampled high.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; rx_s denotes the second flop's output; all decisions SHALL use rx_s only.
REQ-011 HALF SHALL equal (CLKS_PER_BIT-1)/2, integer division.
REQ-012 States SHALL be IDLE, START, DATA, STOP, RECOVER.
REQ-013 IDLE: rx_s==1 SHALL start a frame; this detection cycle is start-bit cycle 0.
REQ-014 Sample points SHALL be detection + HALF (start bit), + HALF + k*CLKS_PER_BIT for k=1..DATA_BITS (data bit k-1), and + HALF + (DATA_BITS+1)*CLKS_PER_BIT (stop bit).
REQ-015 When HALF==0, the start sample SHALL be the detection cycle itself; IDLE SHALL go directly to DATA.
REQ-016 Start sample ==0: false start; SHALL return to IDLE with no output pulse and data unchanged.
REQ-017 DATA: each sample SHALL shift into bit position k-1 of an internal shift register; the bit index counter SHALL be wide enough for DATA_BITS and SHALL not wrap mid-frame.
REQ-018 Stop sample ==0: data SHALL load the shift register; valid SHALL pulse in the next cycle; next state SHALL be IDLE.
REQ-019 Stop sample ==1: frame_err SHALL pulse in the next cycle; data SHALL be unchanged; next state SHALL be RECOVER.
REQ-020 RECOVER SHALL go to IDLE on the first cycle with rx_s==0, preventing a stuck-high line from being read as a start bit.
REQ-021 valid and frame_err SHALL never be high together; each SHALL be high for exactly one cycle per frame.
REQ-022 Latency: rx first high in cycle N gives the valid/frame_err pulse in cycle N+3+HALF+(DATA_BITS+1)*CLKS_PER_BIT; with defaults that is N+12.
REQ-023 Back-to-back: a start bit beginning on rx the cycle after the stop bit ends SHALL be received; no idle gap is required.
REQ-024 The bit-period counter SHALL be $clog2(CLKS_PER_BIT+1) bits wide and SHALL reload at each sample point.

Reset
REQ-025 rst high SHALL immediately force: state IDLE, synchronizer flops 0, counters 0, shift register 0, data 0, valid 0, frame_err 0, busy 0.
REQ-026 Reset mid-frame SHALL abort the frame; no valid or frame_err SHALL result from the aborted frame.
REQ-027 After rst falls, the first start bit SHALL be detectable once it reaches rx_s (2 cycles).

Verification
REQ-028 Defaults; rx = 1, then bits of 0xA5 LSB first, then 0, starting cycle N -> valid high only in cycle N+12, data=0xA5, frame_err 0.
REQ-029 Defaults; frame 0x3C with stop bit 1, then rx held high 5 cycles, then low -> frame_err pulse at N+12, data unchanged, valid 0, busy high through RECOVER, then IDLE.
REQ-030 CLKS_PER_BIT=4; rx high for 1 cycle only -> false start, no pulses, busy returns low within 3 cycles.
REQ-031 Defaults; frames 0x00 and 0xFF back-to-back, no gap -> two valid pulses 10 cycles apart, data 0x00 then 0xFF.
REQ-032 Defaults; rst pulsed during data bit 4 of 0x5A, then frame 0x81 -> no pulse for 0x5A, data 0 after reset, then data=0x81 with one valid pulse.
REQ-033 CLKS_PER_BIT=4, frame 0x81 starting cycle N -> valid high only in cycle N+40, data=0x81.
